button_event_fsm: RTL and testbench



---
 rtl/button_event_if.sv | 23 ++
 rtl/button_event_fsm.sv | 131 +++++++++++++
 tb/tb_button_event_fsm.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/button_event_if.sv
// Button event bundle: debounced level in, event strobes and status out.
interface button_event_if;
   logic       btn;
   logic       press_pulse;
   logic       release_pulse;
   logic       short_press;
   logic       long_press;
   logic       repeat_pulse;
   logic       held;
   logic [7:0] press_cnt;

   modport master (
      output btn,
      input  press_pulse, release_pulse, short_press,
      input  long_press, repeat_pulse, held, press_cnt
   );

   modport slave (
      input  btn,
      output press_pulse, release_pulse, short_press,
      output long_press, repeat_pulse, held, press_cnt
   );
endinterface

// File: rtl/button_event_fsm.sv
// Classifies debounced presses as short/long and emits auto-repeat ticks.
// All event outputs are registered single-cycle strobes.
module button_event_fsm #(
   parameter int CNT_W      = 24,
   parameter int LONG_CYC   = 12_000_000,
   parameter int REPEAT_CYC = 2_400_000
) (
   input  logic        clk,
   input  logic        rst,
   button_event_if.slave bus
);

   typedef enum logic [1:0] {ARM, IDLE, PRESS, HOLD} state_t;

   localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
   localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYC - 1);

   state_t           state, state_n;
   logic             btn_q;
   logic             primed;
   logic [CNT_W-1:0] counter, counter_n;

   logic       press_q, press_n;
   logic       rel_q, rel_n;
   logic       short_q, short_n;
   logic       long_q, long_n;
   logic       rep_q, rep_n;
   logic       held_q, held_n;
   logic [7:0] cnt_q, cnt_n;

   // btn_q is only trusted once it has sampled btn since reset, so a
   // button held through reset is never mistaken for a release.
   always_comb begin
      state_n   = state;
      counter_n = counter;
      press_n   = 1'b0;
      rel_n     = 1'b0;
      short_n   = 1'b0;
      long_n    = 1'b0;
      rep_n     = 1'b0;
      held_n    = held_q;
      cnt_n     = cnt_q;
      unique case (state)
         ARM: begin
            if (primed && !btn_q) begin
               state_n   = IDLE;
               counter_n = '0;
            end
         end
         IDLE: begin
            if (btn_q) begin
               state_n   = PRESS;
               press_n   = 1'b1;
               held_n    = 1'b1;
               cnt_n     = cnt_q + 8'd1;
               counter_n = '0;
            end
         end
         PRESS: begin
            if (!btn_q) begin
               state_n   = IDLE;
               rel_n     = 1'b1;
               short_n   = 1'b1;
               held_n    = 1'b0;
               counter_n = '0;
            end else if (counter == LONG_LAST) begin
               // long_press lands exactly LONG_CYC cycles after press_pulse
               state_n   = HOLD;
               long_n    = 1'b1;
               counter_n = '0;
            end else begin
               counter_n = counter + CNT_W'(1);
            end
         end
         HOLD: begin
            if (!btn_q) begin
               state_n   = IDLE;
               rel_n     = 1'b1;
               held_n    = 1'b0;
               counter_n = '0;
            end else if (counter == REP_LAST) begin
               rep_n     = 1'b1;
               counter_n = '0;
            end else begin
               counter_n = counter + CNT_W'(1);
            end
         end
         default: begin
            state_n   = ARM;
            counter_n = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ARM;
         btn_q   <= 1'b0;
         primed  <= 1'b0;
         counter <= '0;
         press_q <= 1'b0;
         rel_q   <= 1'b0;
         short_q <= 1'b0;
         long_q  <= 1'b0;
         rep_q   <= 1'b0;
         held_q  <= 1'b0;
         cnt_q   <= 8'd0;
      end else begin
         state   <= state_n;
         btn_q   <= bus.btn;
         primed  <= 1'b1;
         counter <= counter_n;
         press_q <= press_n;
         rel_q   <= rel_n;
         short_q <= short_n;
         long_q  <= long_n;
         rep_q   <= rep_n;
         held_q  <= held_n;
         cnt_q   <= cnt_n;
      end
   end

   assign bus.press_pulse   = press_q;
   assign bus.release_pulse = rel_q;
   assign bus.short_press   = short_q;
   assign bus.long_press    = long_q;
   assign bus.repeat_pulse  = rep_q;
   assign bus.held          = held_q;
   assign bus.press_cnt     = cnt_q;

endmodule

// File: tb/tb_button_event_fsm.sv
// Bench for button_event_fsm: directed and random btn traces against a
// hold-time based reference model, checked every cycle.
module tb_button_event_fsm;

   localparam int L = 8;
   localparam int R = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   button_event_if bus ();

   button_event_fsm #(
      .CNT_W      (24),
      .LONG_CYC   (L),
      .REPEAT_CYC (R)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // reference model: hold time measured from the accepted press
   bit       m_bq, m_bq_ok, m_armed, m_active;
   int       m_el;
   logic [7:0] m_cnt;
   bit       e_press, e_rel, e_short, e_long, e_rep, e_held;

   int t_press, t_rel, t_short, t_long, t_rep, t_held;

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_tally();
      t_press = 0; t_rel = 0; t_short = 0;
      t_long  = 0; t_rep = 0; t_held  = 0;
   endtask

   task automatic model_edge(input bit b, input bit r);
      if (r) begin
         {e_press, e_rel, e_short, e_long, e_rep, e_held} = '0;
         m_bq = 0; m_bq_ok = 0; m_armed = 0; m_active = 0;
         m_el = 0; m_cnt = 8'd0;
      end else begin
         {e_press, e_rel, e_short, e_long, e_rep} = '0;
         if (!m_active) begin
            if (m_armed && m_bq) begin
               e_press = 1; e_held = 1; m_active = 1;
               m_el = 0; m_cnt = m_cnt + 8'd1;
            end else if (m_bq_ok && !m_bq) begin
               m_armed = 1;
            end
         end else if (!m_bq) begin
            e_rel = 1; e_short = (m_el < L);
            e_held = 0; m_active = 0;
         end else begin
            m_el++;
            e_long = (m_el == L);
            e_rep  = (m_el > L) && ((m_el - L) % R == 0);
         end
         m_bq = b; m_bq_ok = 1;
      end
   endtask

   task automatic tick(input bit b, input bit r);
      int obs, exp;
      @(negedge clk);
      bus.btn = b;
      rst = r;
      @(posedge clk);
      model_edge(b, r);
      #1;
      t_press += int'(bus.press_pulse);
      t_rel   += int'(bus.release_pulse);
      t_short += int'(bus.short_press);
      t_long  += int'(bus.long_press);
      t_rep   += int'(bus.repeat_pulse);
      t_held  += int'(bus.held);
      obs = int'({bus.press_pulse, bus.release_pulse, bus.short_press,
                  bus.long_press, bus.repeat_pulse, bus.held,
                  bus.press_cnt});
      exp = int'({e_press, e_rel, e_short, e_long, e_rep, e_held, m_cnt});
      check("cycle", obs, exp);
   endtask

   initial begin
      bus.btn = 1'b1;
      rst = 1'b1;
      clear_tally();

      // held through reset: nothing reported
      tick(1, 1); tick(1, 1);
      clear_tally();
      repeat (20) tick(1, 0);
      check("arm_no_press", t_press, 0);
      check("arm_held", int'(bus.held), 0);
      check("arm_cnt", int'(bus.press_cnt), 0);
      tick(0, 0);
      tick(1, 0);
      tick(1, 0);
      check("press_latency", int'(bus.press_pulse), 1);
      check("first_cnt", int'(bus.press_cnt), 1);
      repeat (2) tick(1, 0);
      repeat (4) tick(0, 0);

      // short press
      clear_tally();
      repeat (3) tick(1, 0);
      repeat (4) tick(0, 0);
      check("short_press_cnt", t_press, 1);
      check("short_held_len", t_held, 3);
      check("short_short", t_short, 1);
      check("short_long", t_long, 0);

      // long press with repeats
      clear_tally();
      repeat (20) tick(1, 0);
      repeat (6) tick(0, 0);
      check("long_long", t_long, 1);
      check("long_rep", t_rep, 2);
      check("long_rel", t_rel, 1);
      check("long_short", t_short, 0);

      // release exactly on the threshold cycle
      clear_tally();
      repeat (8) tick(1, 0);
      repeat (6) tick(0, 0);
      check("thr_short", t_short, 1);
      check("thr_long", t_long, 0);
      clear_tally();
      repeat (9) tick(1, 0);
      repeat (6) tick(0, 0);
      check("thr1_long", t_long, 1);
      check("thr1_short", t_short, 0);

      // 257 one-cycle presses wrap press_cnt
      tick(0, 1);
      repeat (2) tick(0, 0);
      clear_tally();
      for (int i = 0; i < 257; i++) begin
         tick(1, 0);
         tick(0, 0);
      end
      repeat (3) tick(0, 0);
      check("wrap_cnt", int'(bus.press_cnt), 1);
      check("wrap_press", t_press, 257);
      check("wrap_rel", t_rel, 257);

      // reset mid-hold with btn still high
      repeat (15) tick(1, 0);
      tick(1, 1);
      clear_tally();
      repeat (5) tick(1, 0);
      check("rst_no_rel", t_rel, 0);
      check("rst_no_press", t_press, 0);
      check("rst_held", int'(bus.held), 0);
      repeat (2) tick(0, 0);
      repeat (3) tick(1, 0);
      repeat (3) tick(0, 0);
      check("rst_rearm", t_press, 1);

      // random traces with occasional reset
      for (int k = 0; k < 40; k++) begin
         int hi = $urandom_range(1, 24);
         int lo = $urandom_range(1, 5);
         for (int j = 0; j < hi; j++)
            tick(1, $urandom_range(0, 99) == 0);
         for (int j = 0; j < lo; j++)
            tick(0, 0);
      end

      $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
      $finish;
   end

endmodule
